ma_store_buffer: RTL and testbench

Parametrised post-commit store buffer that sits between the memory-access stage and the TileLink data bus. Once a store leaves MA it is absorbed here without stalling the pipeline, then drained in order to the bus, one transaction at a time. Loads in MA get byte-accurate forwarding from buffered stores, and a stall when their bytes are only partly covered. Same-doubleword stores coalesce into the youngest idle entry.

---
 rtl/tl_pkg.sv | 14 +
 rtl/sb_lane_align.sv | 16 +
 rtl/ma_store_buffer.sv | 125 ++++++++++++
 tb/tb_ma_store_buffer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: TileLink opcodes, size encoding and store-buffer entry type
package tl_pkg;
  localparam logic [2:0] TL_PUT_FULL    = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK  = 3'd0;
  localparam int DW_W = 61;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef struct packed {
    logic            valid;
    logic [DW_W-1:0] dw_addr;
    logic [7:0]      mask;
    logic [63:0]     data;
  } sb_entry_t;
endpackage

// File: rtl/sb_lane_align.sv
// sb_lane_align: byte-offset/size to lane byte mask and bit shift
module sb_lane_align
  import tl_pkg::*;
(
  input  logic [2:0] off,
  input  logic [1:0] size,
  output logic [7:0] mask,
  output logic [5:0] shift
);
  logic [7:0] base;
  always_comb begin
    base  = (size == SZ_D) ? 8'hff : (size == SZ_W) ? 8'h0f : (size == SZ_H) ? 8'h03 : 8'h01;
    mask  = base << off;
    shift = {off, 3'b000};
  end
endmodule

// File: rtl/ma_store_buffer.sv
// ma_store_buffer: post-commit store buffer with load forwarding and in-order TileLink drain
// st_*: committed store in; ld_*/fwd_*/ld_stall: load forwarding; a_*/d_*: TileLink master; empty: drained
module ma_store_buffer
  import tl_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [1:0]        st_size,
  input  logic [63:0]       st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  output logic              fwd_hit,
  output logic [63:0]       fwd_data,
  output logic              ld_stall,
  output logic              empty,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_size,
  output logic [ADDR_W-1:0] a_address,
  output logic [7:0]        a_mask,
  output logic [63:0]       a_data,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [2:0]        d_opcode
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
  state_e          state, state_nxt;
  sb_entry_t       ent [DEPTH];
  logic [PW-1:0]   head, tail, yng, idx;
  logic [PW:0]     cnt, cnt_nxt;
  logic [7:0]      st_mask, ld_mask, cov;
  logic [5:0]      st_sh, ld_sh;
  logic [63:0]     st_bm, ld_bm, st_lane, fwd_raw;
  logic [DW_W-1:0] st_dw, ld_dw;
  logic            enq, merge, push, pop;
  sb_lane_align u_st_align (.off(st_addr[2:0]), .size(st_size), .mask(st_mask), .shift(st_sh));
  sb_lane_align u_ld_align (.off(ld_addr[2:0]), .size(ld_size), .mask(ld_mask), .shift(ld_sh));
  always_comb begin
    for (int b = 0; b < 8; b++) begin
      st_bm[8*b +: 8] = {8{st_mask[b]}};
      ld_bm[8*b +: 8] = {8{ld_mask[b]}};
    end
  end
  assign st_dw    = DW_W'(st_addr[ADDR_W-1:3]);
  assign ld_dw    = DW_W'(ld_addr[ADDR_W-1:3]);
  assign st_lane  = (st_data << st_sh) & st_bm;
  assign yng      = tail - PW'(1);
  assign st_ready = cnt != FULL;
  assign enq      = st_valid & st_ready & ~clear;
  // the head is frozen once the drain FSM has picked it up, so it never absorbs a merge
  assign merge    = enq & ent[yng].valid & (ent[yng].dw_addr == st_dw) & ~((state != S_IDLE) & (yng == head));
  assign push     = enq & ~merge;
  assign pop      = (state == S_WAIT) & d_valid & (d_opcode == TL_ACCESS_ACK);
  assign cnt_nxt  = cnt + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  assign empty    = (cnt == '0) & (state == S_IDLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (pop) begin
        ent[head].valid <= 1'b0;
        head            <= head + PW'(1);
      end
      if (push) begin
        ent[tail] <= '{1'b1, st_dw, st_mask, st_lane};
        tail      <= tail + PW'(1);
      end
      if (merge) begin
        ent[yng].mask <= ent[yng].mask | st_mask;
        ent[yng].data <= (ent[yng].data & ~st_bm) | st_lane;
      end
    end
  end
  // looking at next count lets a fresh store or a pop-with-more-pending go straight to REQ
  always_comb begin
    state_nxt = (state == S_IDLE) ? ((cnt_nxt != '0) ? S_REQ : S_IDLE) :
                (state == S_REQ)  ? (a_ready ? S_WAIT : S_REQ) :
                pop ? ((cnt_nxt != '0) ? S_REQ : S_IDLE) : S_WAIT;
  end
  always_comb begin
    a_valid   = state == S_REQ;
    d_ready   = state == S_WAIT;
    a_opcode  = a_valid ? ((ent[head].mask == 8'hff) ? TL_PUT_FULL : TL_PUT_PARTIAL) : 3'd0;
    a_size    = a_valid ? 3'd3 : 3'd0;
    a_address = a_valid ? {ent[head].dw_addr[ADDR_W-4:0], 3'b000} : '0;
    a_mask    = a_valid ? ent[head].mask : 8'h00;
    a_data    = a_valid ? ent[head].data : 64'h0;
  end
  // walk oldest to youngest so the youngest covering entry wins each byte
  always_comb begin
    cov     = '0;
    fwd_raw = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      for (int b = 0; b < 8; b++) begin
        if (ent[idx].valid && ent[idx].dw_addr == ld_dw && ent[idx].mask[b]) begin
          cov[b]            = 1'b1;
          fwd_raw[8*b +: 8] = ent[idx].data[8*b +: 8];
        end
      end
    end
    cov      = cov & ld_mask;
    fwd_hit  = ld_valid & (cov == ld_mask);
    ld_stall = ld_valid & (|cov) & (cov != ld_mask);
    fwd_data = ld_valid ? ((fwd_raw & ld_bm) >> ld_sh) : 64'h0;
  end
endmodule

// File: tb/tb_ma_store_buffer.sv
// tb_ma_store_buffer: directed self-checking bench for ma_store_buffer
module tb_ma_store_buffer;
  logic        clk = 0, rst_n = 0, clear = 0;
  logic        st_valid = 0, st_ready, ld_valid = 0, fwd_hit, ld_stall, empty;
  logic [63:0] st_addr = 0, st_data = 0, ld_addr = 0, fwd_data, a_address, a_data;
  logic [1:0]  st_size = 0, ld_size = 0;
  logic        a_valid, a_ready = 0, d_valid = 0, d_ready;
  logic [2:0]  a_opcode, a_size, d_opcode = 0;
  logic [7:0]  a_mask;
  int          n_cmp = 0, n_err = 0;

  ma_store_buffer #(.DEPTH(4), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .st_valid(st_valid), .st_addr(st_addr), .st_size(st_size), .st_data(st_data), .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall), .empty(empty),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [63:0] addr, input logic [1:0] size, input logic [63:0] data);
    st_valid = 1; st_addr = addr; st_size = size; st_data = data;
    step();
    st_valid = 0;
  endtask

  task automatic load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                      input logic hit, input logic stall, input logic [63:0] data);
    ld_valid = 1; ld_addr = addr; ld_size = size;
    #1;
    chk({tag, ".hit"}, fwd_hit, hit);
    chk({tag, ".stall"}, ld_stall, stall);
    if (hit) chk({tag, ".data"}, fwd_data, data);
    ld_valid = 0;
  endtask

  task automatic beat(input string tag, input logic [2:0] op, input logic [7:0] m,
                      input logic [63:0] addr, input logic [63:0] data);
    chk({tag, ".a_valid"}, a_valid, 1);
    chk({tag, ".opcode"}, a_opcode, op);
    chk({tag, ".size"}, a_size, 3);
    chk({tag, ".mask"}, a_mask, m);
    chk({tag, ".addr"}, a_address, addr);
    chk({tag, ".data"}, a_data, data);
    a_ready = 1;
    step();
    a_ready = 0;
    chk({tag, ".d_ready"}, d_ready, 1);
    d_valid = 1; d_opcode = 0;
    step();
    d_valid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst.st_ready", st_ready, 1);
    chk("rst.empty", empty, 1);
    chk("rst.a_valid", a_valid, 0);
    chk("rst.d_ready", d_ready, 0);
    chk("rst.fwd_hit", fwd_hit, 0);
    @(negedge clk) rst_n = 1;
    step();

    // single full dword
    a_ready = 1;
    store(64'h1000, 2'd3, 64'h1122334455667788);
    chk("t1.empty_busy", empty, 0);
    beat("t1", 3'd0, 8'hff, 64'h1000, 64'h1122334455667788);
    chk("t1.empty", empty, 1);

    // coalescing behind an in-flight head
    store(64'h2800, 2'd3, 64'h0102030405060708);
    store(64'h2003, 2'd0, 64'hAA);
    store(64'h2004, 2'd0, 64'hBB);
    load("t2.ldb", 64'h2004, 2'd0, 1, 0, 64'hBB);
    load("t2.ldh", 64'h2004, 2'd1, 0, 1, 0);
    beat("t2.b0", 3'd0, 8'hff, 64'h2800, 64'h0102030405060708);
    chk("t2.lane", a_data[39:24], 16'hBBAA);
    chk("t2.op", a_opcode, 3'd1);
    chk("t2.mask", a_mask, 8'h18);
    chk("t2.addr", a_address, 64'h2000);
    a_ready = 1;
    step();
    a_ready = 0;
    d_valid = 1; d_opcode = 3'd1;
    step();
    chk("t2.ignored_d", d_ready, 1);
    chk("t2.not_empty", empty, 0);
    d_opcode = 3'd0;
    step();
    d_valid = 0;
    chk("t2.empty", empty, 1);

    // forwarding
    store(64'h3000, 2'd2, 64'hDEADBEEF);
    load("t3.word", 64'h3000, 2'd2, 1, 0, 64'hDEADBEEF);
    load("t3.dword", 64'h3000, 2'd3, 0, 1, 0);
    load("t3.miss", 64'h3008, 2'd3, 0, 0, 0);
    load("t3.byte", 64'h3002, 2'd0, 1, 0, 64'hAD);
    store(64'h3000, 2'd0, 64'h11);
    load("t3.young", 64'h3000, 2'd2, 1, 0, 64'hDEADBE11);
    st_valid = 1; st_addr = 64'h3010; st_size = 2'd3; st_data = 64'h0123456789ABCDEF;
    ld_valid = 1; ld_addr = 64'h3010; ld_size = 2'd3;
    #1;
    chk("t3.nobypass", fwd_hit, 0);
    step();
    st_valid = 0;
    #1;
    chk("t3.after.hit", fwd_hit, 1);
    chk("t3.after.data", fwd_data, 64'h0123456789ABCDEF);
    ld_valid = 0;
    beat("t3.b0", 3'd1, 8'h0f, 64'h3000, 64'hDEADBEEF);
    beat("t3.b1", 3'd1, 8'h01, 64'h3000, 64'h11);
    beat("t3.b2", 3'd0, 8'hff, 64'h3010, 64'h0123456789ABCDEF);
    chk("t3.empty", empty, 1);

    // fill and in-order drain
    for (int i = 0; i < 4; i++) store(64'h4000 + 64'(8 * i), 2'd3, 64'hA0 + 64'(i));
    chk("t4.full", st_ready, 0);
    chk("t4.head", a_address, 64'h4000);
    a_ready = 1;
    step();
    a_ready = 0;
    d_valid = 1; d_opcode = 0;
    #1;
    chk("t4.full_pop", st_ready, 0);
    step();
    d_valid = 0;
    chk("t4.ready", st_ready, 1);
    for (int i = 1; i < 4; i++) beat("t4.b", 3'd0, 8'hff, 64'h4000 + 64'(8 * i), 64'hA0 + 64'(i));
    chk("t4.empty", empty, 1);

    // clear blocks enqueue
    store(64'h5000, 2'd3, 64'h55);
    clear = 1;
    store(64'h5008, 2'd3, 64'h66);
    clear = 0;
    load("t5.ld", 64'h5008, 2'd3, 0, 0, 0);
    beat("t5.b0", 3'd0, 8'hff, 64'h5000, 64'h55);
    chk("t5.empty", empty, 1);

    // async reset while waiting for the ack
    for (int i = 0; i < 4; i++) store(64'h6000 + 64'(8 * i), 2'd3, 64'h60 + 64'(i));
    a_ready = 1;
    step();
    a_ready = 0;
    chk("t6.wait", d_ready, 1);
    chk("t6.full", st_ready, 0);
    #2 rst_n = 0;
    #1;
    chk("t6.a_valid", a_valid, 0);
    chk("t6.d_ready", d_ready, 0);
    chk("t6.empty", empty, 1);
    chk("t6.st_ready", st_ready, 1);
    @(negedge clk) rst_n = 1;
    step();
    load("t6.ld", 64'h6000, 2'd3, 0, 0, 0);
    chk("t6.idle", a_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
